// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

    typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_t;

    localparam logic [15:0] IO_ADDR    = 16'hFFFF;
    localparam int          WAIT_CNT_W = 4;

endpackage

// File: rtl/slc3_mem_responder_if.sv
// MAR/MDR request/response bus between SLC-3 control (master) and the memory responder (slave).
interface slc3_mem_responder_if;

    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] ADDR;
    logic [15:0] DATA_W;
    logic [15:0] MDR_In;
    logic        MEM_RDY;
    logic        MEM_ERR;

    modport master (
        output MEM_REQ, MEM_WE, ADDR, DATA_W,
        input  MDR_In, MEM_RDY, MEM_ERR
    );

    modport slave (
        input  MEM_REQ, MEM_WE, ADDR, DATA_W,
        output MDR_In, MEM_RDY, MEM_ERR
    );

endinterface

// File: rtl/slc3_sram_1p.sv
// Synchronous single-port 16-bit RAM: one read or one write per enabled edge, registered read.
module slc3_sram_1p #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [15:0]           wdata_i,
    output logic [15:0]           rdata_o
);

    logic [15:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: wait-stated RAM access over the MAR/MDR bus.
// Define SLC3_IO_MAP_EN to map switches (read) and the hex display register (write) at 16'hFFFF.
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    slc3_mem_responder_if.slave  bus,
    input  logic [15:0]          SW,
    output logic [15:0]          HEX_OUT
);

    // 17 bits so a full 64K-word RAM still has a representable bound.
    localparam logic [16:0] RamWords = 17'(1) << DEPTH_LOG2;
    localparam logic [WAIT_CNT_W-1:0] WaitLoad =
        WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    mem_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]           addr_q, wdata_q;
    logic                  we_q;

    logic [15:0] acc_addr, acc_wdata;
    logic        acc_we;
    logic        commit;
    logic        is_ram_acc, is_io_acc, is_ram_q, is_io_q;
    logic [15:0] ram_rdata, io_rdata;
    logic        rdy;

    // With no wait states the commit edge is also the accept edge, so take the live bus in IDLE.
    always_comb begin
        if (state_q == MEM_IDLE) begin
            acc_addr  = bus.ADDR;
            acc_we    = bus.MEM_WE;
            acc_wdata = bus.DATA_W;
        end else begin
            acc_addr  = addr_q;
            acc_we    = we_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (bus.MEM_REQ) begin
                    if (WAIT_STATES > 0) begin
                        state_d = MEM_WAIT;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = MEM_RESP;
                    end
                end
            end
            MEM_WAIT: begin
                if (!bus.MEM_REQ) begin
                    state_d = MEM_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = MEM_RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            MEM_RESP: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == MEM_IDLE && bus.MEM_REQ) begin
                addr_q  <= bus.ADDR;
                we_q    <= bus.MEM_WE;
                wdata_q <= bus.DATA_W;
            end
        end
    end

    assign commit     = (state_d == MEM_RESP);
    assign is_ram_acc = ({1'b0, acc_addr} < RamWords);
    assign is_ram_q   = ({1'b0, addr_q} < RamWords);

`ifdef SLC3_IO_MAP_EN
    logic [15:0] sw_q, hex_q;

    assign is_io_acc = (acc_addr == IO_ADDR);
    assign is_io_q   = (addr_q == IO_ADDR);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_q  <= '0;
            hex_q <= '0;
        end else if (commit && is_io_acc) begin
            if (acc_we) begin
                hex_q <= acc_wdata;
            end else begin
                sw_q <= SW;
            end
        end
    end

    assign io_rdata = sw_q;
    assign HEX_OUT  = hex_q;
`else
    logic unused_sw;

    assign unused_sw = ^SW;
    assign is_io_acc = 1'b0;
    assign is_io_q   = 1'b0;
    assign io_rdata  = '0;
    assign HEX_OUT   = '0;
`endif

    slc3_sram_1p #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk_i  (Clk),
        .en_i   (commit && is_ram_acc && !is_io_acc),
        .we_i   (acc_we),
        .addr_i (acc_addr[DEPTH_LOG2-1:0]),
        .wdata_i(acc_wdata),
        .rdata_o(ram_rdata)
    );

    assign rdy         = (state_q == MEM_RESP);
    assign bus.MEM_RDY = rdy;
    assign bus.MEM_ERR = rdy && !is_ram_q && !is_io_q;

    // RAM output register is not reset, so data is gated to the response cycle.
    always_comb begin
        bus.MDR_In = '0;
        if (rdy) begin
            if (is_io_q) begin
                bus.MDR_In = io_rdata;
            end else if (is_ram_q) begin
                bus.MDR_In = ram_rdata;
            end
        end
    end

endmodule
